register_file_mp: RTL and testbench

Parametrised multi-read-port register file for the multicycle MIPS datapath. It replaces the fixed 32x32, two-read-port file and adds four things: a hardwired zero register, write-through bypass, a pending-write scoreboard with per-port busy flags, and a self-sequenced initialisation sweep after reset. It sits between decode/operand fetch and writeback.

---
 rtl/register_file_mp.sv | 101 ++++++++++
 tb/tb_register_file_mp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional hardwired zero register, write-through
// bypass, pending-write scoreboard and a post-reset sweep that loads mem[i] = i.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [NUM_RD*ADDR_W-1:0]   readRegs,
    output logic [NUM_RD*DATA_W-1:0]   readData,
    input  logic                       reserve,
    input  logic [ADDR_W-1:0]          reserveReg,
    output logic [NUM_RD-1:0]          busy,
    output logic                       initDone
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, READY} state_t;

    state_t              state, nextState;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic                ready;
    logic                writeEn;
    logic                reserveEn;

    assign ready     = (state == READY);
    assign writeEn   = ready && regWrite && !(ZERO_REG && (writeReg == '0));
    assign reserveEn = ready && reserve && !(ZERO_REG && (reserveReg == '0));
    assign initDone  = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (state == INIT && (&ptr)) begin
            nextState = READY;
        end
    end

    // The sweep pointer stops on its last value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == INIT && !(&ptr)) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[ptr] <= DATA_W'(ptr);
            end else if (writeEn) begin
                mem[writeReg] <= writeData;
            end
        end
    end

    // Reserve is applied after the clear so a same-register reserve from a newer instruction wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (writeEn) begin
                pending[writeReg] <= 1'b0;
            end
            if (reserveEn) begin
                pending[reserveReg] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic              isZero;
        logic              hit;

        assign addr   = readRegs[g*ADDR_W +: ADDR_W];
        assign isZero = ZERO_REG && (addr == '0);
        assign hit    = writeEn && (writeReg == addr);

        assign readData[g*DATA_W +: DATA_W] = (!ready || isZero) ? '0 :
                                              hit ? writeData : mem[addr];
        assign busy[g] = ready && !isZero && pending[addr] && !hit;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default configuration plus a 16-bit, 8-entry,
// four-port instance without a zero register.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, regWriteA, reserveA;
    logic [4:0]  writeRegA, reserveRegA;
    logic [31:0] writeDataA;
    logic [9:0]  readRegsA;
    logic [63:0] readDataA;
    logic [1:0]  busyA;
    logic        initDoneA;

    logic        rstB, regWriteB, reserveB;
    logic [2:0]  writeRegB, reserveRegB;
    logic [15:0] writeDataB;
    logic [11:0] readRegsB;
    logic [63:0] readDataB;
    logic [3:0]  busyB;
    logic        initDoneB;

    register_file_mp dutA (
        .clk(clk), .rst(rstA), .regWrite(regWriteA), .writeReg(writeRegA),
        .writeData(writeDataA), .readRegs(readRegsA), .readData(readDataA),
        .reserve(reserveA), .reserveReg(reserveRegA), .busy(busyA), .initDone(initDoneA)
    );

    register_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b0)) dutB (
        .clk(clk), .rst(rstB), .regWrite(regWriteB), .writeReg(writeRegB),
        .writeData(writeDataB), .readRegs(readRegsB), .readData(readDataB),
        .reserve(reserveB), .reserveReg(reserveRegB), .busy(busyB), .initDone(initDoneB)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    int edges;

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    initial begin
        rstA = 1; regWriteA = 0; reserveA = 0; writeRegA = 0; reserveRegA = 0;
        writeDataA = 0; readRegsA = 0;
        rstB = 1; regWriteB = 0; reserveB = 0; writeRegB = 0; reserveRegB = 0;
        writeDataB = 0; readRegsB = 0;

        // Init sweep on the default instance
        applyStimulus(1);
        rstA = 0;
        readRegsA = {5'd31, 5'd7};
        #1;
        checkOutput("A reset initDone", 64'(initDoneA), 64'd0);
        checkOutput("A reset busy", 64'(busyA), 64'd0);
        checkOutput("A reset readData", readDataA, 64'd0);
        regWriteA = 1; writeRegA = 7; writeDataA = 32'hFFFF_FFFF;
        reserveA = 1; reserveRegA = 7;
        applyStimulus(31);
        checkOutput("A initDone after 31", 64'(initDoneA), 64'd0);
        checkOutput("A INIT busy", 64'(busyA), 64'd0);
        regWriteA = 0; reserveA = 0;
        applyStimulus(1);
        checkOutput("A initDone after 32", 64'(initDoneA), 64'd1);
        checkOutput("A sweep values 7/31", readDataA, {32'd31, 32'd7});
        checkOutput("A ignored INIT reserve", 64'(busyA), 64'd0);

        // Write, bypass and zero register
        regWriteA = 1; writeRegA = 5; writeDataA = 32'hDEAD_BEEF;
        readRegsA = {5'd0, 5'd5};
        #1;
        checkOutput("A bypass reg5", readDataA, {32'd0, 32'hDEAD_BEEF});
        applyStimulus(1);
        regWriteA = 0;
        #1;
        checkOutput("A stored reg5", readDataA, {32'd0, 32'hDEAD_BEEF});
        regWriteA = 1; writeRegA = 0; writeDataA = 32'h1234;
        readRegsA = {5'd5, 5'd0};
        #1;
        checkOutput("A zero bypass suppressed", readDataA, {32'hDEAD_BEEF, 32'd0});
        applyStimulus(1);
        regWriteA = 0;
        #1;
        checkOutput("A zero reg reads 0", readDataA, {32'hDEAD_BEEF, 32'd0});

        // Scoreboard
        reserveA = 1; reserveRegA = 9; readRegsA = {5'd9, 5'd9};
        #1;
        checkOutput("A busy before reserve edge", 64'(busyA), 64'd0);
        applyStimulus(1);
        reserveA = 0;
        #1;
        checkOutput("A busy reg9 dup ports", 64'(busyA), 64'b11);
        regWriteA = 1; writeRegA = 9; writeDataA = 32'hA5;
        #1;
        checkOutput("A busy covered by bypass", 64'(busyA), 64'd0);
        checkOutput("A bypass reg9", readDataA, {32'hA5, 32'hA5});
        applyStimulus(1);
        regWriteA = 0;
        #1;
        checkOutput("A pending cleared reg9", 64'(busyA), 64'd0);
        checkOutput("A stored reg9", readDataA, {32'hA5, 32'hA5});

        reserveA = 1; reserveRegA = 12; regWriteA = 1; writeRegA = 12; writeDataA = 32'h77;
        applyStimulus(1);
        reserveA = 0; regWriteA = 0; readRegsA = {5'd0, 5'd12};
        #1;
        checkOutput("A reserve wins reg12", 64'(busyA), 64'b01);
        checkOutput("A reg12 data", readDataA, {32'd0, 32'h77});

        reserveA = 1; reserveRegA = 3; regWriteA = 1; writeRegA = 4; writeDataA = 32'h44;
        applyStimulus(1);
        reserveA = 0; regWriteA = 0; readRegsA = {5'd4, 5'd3};
        #1;
        checkOutput("A reserve3 write4 busy", 64'(busyA), 64'b01);
        checkOutput("A reg4 data", readDataA[63:32], 64'h44);

        reserveA = 1; reserveRegA = 0;
        applyStimulus(1);
        reserveA = 0; readRegsA = {5'd3, 5'd0};
        #1;
        checkOutput("A reg0 never busy", 64'(busyA), 64'b10);

        // Reset mid-operation restarts the sweep
        reserveA = 1; reserveRegA = 2;
        applyStimulus(1);
        reserveA = 0; readRegsA = {5'd3, 5'd2};
        #1;
        checkOutput("A pending 2 and 3", 64'(busyA), 64'b11);
        rstA = 1;
        applyStimulus(1);
        rstA = 0;
        #1;
        checkOutput("A mid reset busy", 64'(busyA), 64'd0);
        checkOutput("A mid reset initDone", 64'(initDoneA), 64'd0);
        checkOutput("A mid reset readData", readDataA, 64'd0);
        edges = 0;
        for (int k = 0; k < 40 && !initDoneA; k++) begin
            applyStimulus(1);
            edges++;
        end
        checkOutput("A resweep initDone", 64'(initDoneA), 64'd1);
        checkOutput("A resweep edge count", 64'(edges), 64'd32);
        readRegsA = {5'd2, 5'd5};
        #1;
        checkOutput("A reg5 restored", readDataA, {32'd2, 32'd5});
        checkOutput("A pending gone after reset", 64'(busyA), 64'd0);

        // Narrow, four-port instance without a zero register
        applyStimulus(1);
        rstB = 0;
        applyStimulus(7);
        checkOutput("B initDone after 7", 64'(initDoneB), 64'd0);
        applyStimulus(1);
        checkOutput("B initDone after 8", 64'(initDoneB), 64'd1);
        readRegsB = {3'd7, 3'd6, 3'd5, 3'd4};
        #1;
        checkOutput("B four ports sweep", readDataB, {16'd7, 16'd6, 16'd5, 16'd4});
        regWriteB = 1; writeRegB = 0; writeDataB = 16'hBEEF; readRegsB = {3'd0, 3'd3, 3'd7, 3'd0};
        #1;
        checkOutput("B reg0 bypass", readDataB, {16'hBEEF, 16'd3, 16'd7, 16'hBEEF});
        applyStimulus(1);
        regWriteB = 0; reserveB = 1; reserveRegB = 0;
        #1;
        checkOutput("B reg0 stored", readDataB, {16'hBEEF, 16'd3, 16'd7, 16'hBEEF});
        applyStimulus(1);
        reserveB = 0;
        #1;
        checkOutput("B reg0 busy", 64'(busyB), 64'b1001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
